// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port RAM among
// NUM_REQ requesters. Each granted access completes in the grant cycle; a
// granted read returns rvalid one cycle later, aligned with the RAM's
// registered read data.
// Optional feature: define MEM_ARB_LOCK_EN to let a winner holding lock_in
// keep the port for up to MAX_LOCK consecutive grants (burst retention).
module mem_port_arbiter #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int ADDR_WIDTH       = 8,
    parameter int NUM_REQ          = 4,
    parameter int MAX_LOCK         = 16
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_in,
    input  logic [NUM_REQ-1:0]                    wb_in,
    input  logic [NUM_REQ-1:0]                    lock_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         addr_in,
    input  logic [NUM_REQ*MEMORY_BUS_WIDTH-1:0]   data_in,
    output logic [NUM_REQ-1:0]                    gnt_out,
    output logic [NUM_REQ-1:0]                    rvalid_out,
    output logic [MEMORY_BUS_WIDTH-1:0]           rdata_out,
    output logic                                  mem_enable_out,
    output logic                                  mem_wb_out,
    output logic [ADDR_WIDTH-1:0]                 mem_addr_out,
    output logic [MEMORY_BUS_WIDTH-1:0]           mem_data_out,
    input  logic [MEMORY_BUS_WIDTH-1:0]           mem_data_in
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]            r_last_winner;
    logic [NUM_REQ-1:0]          r_rvalid;
    logic [IDX_W-1:0]            w_rr_idx;
    logic                        w_rr_found;
    logic                        w_lock_hit;
    logic                        w_valid;
    logic [IDX_W-1:0]            w_win_idx;
    logic [NUM_REQ-1:0]          w_gnt;
    logic                        w_wb;
    logic [ADDR_WIDTH-1:0]       w_addr;
    logic [MEMORY_BUS_WIDTH-1:0] w_data;

    // Round-robin search starting one past the previous winner
    always_comb begin
        int idx_v;
        w_rr_idx   = '0;
        w_rr_found = 1'b0;
        idx_v      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_v = (int'(r_last_winner) + k) % NUM_REQ;
            if (!w_rr_found && req_in[idx_v]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IDX_W'(idx_v);
            end else begin
                w_rr_found = w_rr_found;
            end
        end
    end

`ifdef MEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic             r_lock_active;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // A live lock only holds while its owner keeps requesting
    always_comb begin
        w_lock_hit = r_lock_active & req_in[r_last_winner];
        if (w_lock_hit) begin
            w_cnt_next = r_lock_cnt + CNT_W'(1);
        end else begin
            w_cnt_next = CNT_W'(1);
        end
    end

    // Lock state: armed by a locking winner, dropped after MAX_LOCK grants
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lock_active <= 1'b0;
            r_lock_cnt    <= '0;
        end else if (w_valid) begin
            r_lock_cnt    <= w_cnt_next;
            r_lock_active <= lock_in[w_win_idx] && (w_cnt_next < CNT_W'(MAX_LOCK));
        end else begin
            r_lock_active <= 1'b0;
            r_lock_cnt    <= '0;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^lock_in;
    assign w_lock_hit    = 1'b0;
`endif

    // Winner selection and RAM port mux; everything is quiet with no grant
    always_comb begin
        w_valid   = reset & (w_lock_hit | w_rr_found);
        w_win_idx = w_lock_hit ? r_last_winner : w_rr_idx;
        w_gnt     = '0;
        w_wb      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        if (w_valid) begin
            w_gnt[w_win_idx] = 1'b1;
            w_wb             = wb_in[w_win_idx];
            w_addr           = addr_in[w_win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            w_data           = data_in[w_win_idx*MEMORY_BUS_WIDTH +: MEMORY_BUS_WIDTH];
        end else begin
            w_gnt = '0;
        end
    end

    // Remember the last winner so the next search starts after it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_winner <= LAST_INIT;
        end else if (w_valid) begin
            r_last_winner <= w_win_idx;
        end else begin
            r_last_winner <= r_last_winner;
        end
    end

    // Read-return flag follows a granted read by exactly one cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_gnt & {NUM_REQ{~w_wb}};
        end
    end

    assign gnt_out        = w_gnt;
    assign rvalid_out     = r_rvalid;
    assign rdata_out      = mem_data_in;
    assign mem_enable_out = w_valid;
    assign mem_wb_out     = w_wb;
    assign mem_addr_out   = w_addr;
    assign mem_data_out   = w_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (4 requesters, 32-bit data).
// Includes a behavioural RAM with one-cycle registered read latency; an
// unwritten word reads back as its own address.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 4;

    logic            clock;
    logic            reset;
    logic [NR-1:0]   req_in;
    logic [NR-1:0]   wb_in;
    logic [NR-1:0]   lock_in;
    logic [NR*AW-1:0] addr_in;
    logic [NR*DW-1:0] data_in;
    logic [NR-1:0]   gnt_out;
    logic [NR-1:0]   rvalid_out;
    logic [DW-1:0]   rdata_out;
    logic            mem_enable_out;
    logic            mem_wb_out;
    logic [AW-1:0]   mem_addr_out;
    logic [DW-1:0]   mem_data_out;
    logic [DW-1:0]   mem_data_in;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0]   ram [0:255];
    logic [255:0]    ram_written;

    mem_port_arbiter #(
        .MEMORY_BUS_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .MAX_LOCK(16)
    ) dut (
        .clock(clock), .reset(reset), .req_in(req_in), .wb_in(wb_in),
        .lock_in(lock_in), .addr_in(addr_in), .data_in(data_in),
        .gnt_out(gnt_out), .rvalid_out(rvalid_out), .rdata_out(rdata_out),
        .mem_enable_out(mem_enable_out), .mem_wb_out(mem_wb_out),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM: writes land at the edge, reads return one cycle later
    always @(posedge clock) begin
        if (!reset) begin
            ram_written <= '0;
            mem_data_in <= '0;
        end else if (mem_enable_out) begin
            if (mem_wb_out) begin
                ram[mem_addr_out]         <= mem_data_out;
                ram_written[mem_addr_out] <= 1'b1;
            end else begin
                mem_data_in <= ram_written[mem_addr_out] ? ram[mem_addr_out]
                                                         : {24'd0, mem_addr_out};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic wb, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_in[i]              = wb;
        addr_in[i*AW +: AW]   = a;
        data_in[i*DW +: DW]   = d;
    endtask

    logic [NR-1:0] exp_g;

    initial begin
        reset   = 1'b0;
        req_in  = '0;
        wb_in   = '0;
        lock_in = '0;
        addr_in = '0;
        data_in = '0;
        tick();
        tick();
        chk("reset_rvalid", 64'(rvalid_out), 64'd0);
        chk("reset_gnt", 64'(gnt_out), 64'd0);
        chk("reset_mem_en", 64'(mem_enable_out), 64'd0);
        reset = 1'b1;
        tick();

        // Four simultaneous readers rotate 0,1,2,3; each word reads back its address
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i), 32'd0);
        req_in = 4'b1111;
        for (int c = 0; c < NR; c++) begin
            #1;
            chk("rr_gnt", 64'(gnt_out), 64'(4'b0001 << c));
            chk("rr_mem_en", 64'(mem_enable_out), 64'd1);
            chk("rr_mem_addr", 64'(mem_addr_out), 64'(c));
            tick();
            chk("rr_rvalid", 64'(rvalid_out), 64'(4'b0001 << c));
            chk("rr_rdata", 64'(rdata_out), 64'(c));
        end
        req_in = 4'b0000;

        // Single read by requester 2 at address 0x05
        set_req(2, 1'b0, 8'h05, 32'd0);
        req_in = 4'b0100;
        #1;
        chk("r2_gnt", 64'(gnt_out), 64'h4);
        chk("r2_mem_addr", 64'(mem_addr_out), 64'h05);
        chk("r2_mem_wb", 64'(mem_wb_out), 64'd0);
        tick();
        req_in = 4'b0000;
        chk("r2_rvalid", 64'(rvalid_out), 64'h4);
        chk("r2_rdata", 64'(rdata_out), 64'h5);

        // Make requester 0 the last winner, then write(1) vs read(3) at 0x10
        set_req(0, 1'b0, 8'h00, 32'd0);
        req_in = 4'b0001;
        #1;
        chk("w0_gnt", 64'(gnt_out), 64'h1);
        tick();
        set_req(1, 1'b1, 8'h10, 32'h0000_00A5);
        set_req(3, 1'b0, 8'h10, 32'd0);
        req_in = 4'b1010;
        #1;
        chk("wr_gnt", 64'(gnt_out), 64'h2);
        chk("wr_mem_wb", 64'(mem_wb_out), 64'd1);
        chk("wr_mem_addr", 64'(mem_addr_out), 64'h10);
        chk("wr_mem_data", 64'(mem_data_out), 64'hA5);
        chk("wr_rvalid_prev", 64'(rvalid_out), 64'h1);
        tick();
        req_in = 4'b1000;
        #1;
        chk("rd3_gnt", 64'(gnt_out), 64'h8);
        chk("wr_no_rvalid", 64'(rvalid_out), 64'h0);
        tick();
        req_in = 4'b0000;
        chk("rd3_rvalid", 64'(rvalid_out), 64'h8);
        chk("rd3_rdata", 64'(rdata_out), 64'hA5);

        // Idle: port fully quiet
        #1;
        chk("idle_gnt", 64'(gnt_out), 64'd0);
        chk("idle_mem_en", 64'(mem_enable_out), 64'd0);
        chk("idle_mem_wb", 64'(mem_wb_out), 64'd0);
        chk("idle_mem_addr", 64'(mem_addr_out), 64'd0);
        chk("idle_mem_data", 64'(mem_data_out), 64'd0);
        tick();

        // Requester 0 locks, requester 1 competes, 20 cycles of writes
        set_req(0, 1'b1, 8'h20, 32'h1111_1111);
        set_req(1, 1'b1, 8'h21, 32'h2222_2222);
        lock_in = 4'b0001;
        req_in  = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            #1;
`ifdef MEM_ARB_LOCK_EN
            exp_g = (i == 16) ? 4'b0010 : 4'b0001;
`else
            exp_g = (i % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
            chk("lock_seq_gnt", 64'(gnt_out), 64'(exp_g));
            tick();
        end
        req_in  = 4'b0000;
        lock_in = 4'b0000;
        tick();

        // Reset asserted while a read is being granted: no rvalid afterwards
        set_req(2, 1'b0, 8'h05, 32'd0);
        req_in = 4'b0100;
        #1;
        chk("rst_rd_gnt", 64'(gnt_out), 64'h4);
        reset = 1'b0;
        #1;
        chk("rst_rd_rvalid_async", 64'(rvalid_out), 64'h0);
        tick();
        req_in = 4'b0000;
        reset  = 1'b1;
        chk("rst_rd_rvalid_rel", 64'(rvalid_out), 64'h0);
        tick();
        chk("rst_rd_rvalid_late", 64'(rvalid_out), 64'h0);

        // First grant after release goes to requester 0
        req_in = 4'b1111;
        #1;
        chk("post_rst_gnt", 64'(gnt_out), 64'h1);
        tick();
        req_in = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
